// File: rtl/io_bridge.sv
// rtl/io_bridge.sv - host-side processor I/O bridge: host->core input FIFO and core->host output FIFO
// Optional feature macro IO_BRIDGE_STATS_EN adds rd_count/wr_count transfer counters.
module io_bridge #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clock,
   input  logic              rst,
   input  logic [DATA_W-1:0] host_in_data,
   input  logic              host_in_valid,
   output logic              host_in_ready,
   output logic [DATA_W-1:0] proc_read_in,
   input  logic              proc_rd,
   output logic              proc_rd_stall,
   input  logic [DATA_W-1:0] proc_write_out,
   input  logic              proc_wr,
   output logic [DATA_W-1:0] host_out_data,
   output logic              host_out_valid,
   input  logic              host_out_ready,
`ifdef IO_BRIDGE_STATS_EN
   output logic              overflow,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
`else
   output logic              overflow
`endif
);

   localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

   logic [DATA_W-1:0] in_mem  [DEPTH];
   logic [DATA_W-1:0] out_mem [DEPTH];
   logic [ADDR_W-1:0] in_wp, in_rp, out_wp, out_rp;
   logic [ADDR_W:0]   in_cnt, out_cnt;

   logic in_full, in_empty, in_push, in_pop;
   logic out_full, out_empty, out_push, out_pop, out_drop;

   assign in_full   = (in_cnt == CNT_FULL);
   assign in_empty  = (in_cnt == '0);
   assign out_full  = (out_cnt == CNT_FULL);
   assign out_empty = (out_cnt == '0);

   // Every handshake is qualified with !rst so nothing moves during reset.
   assign host_in_ready = !in_full && !rst;
   assign in_push       = host_in_valid && host_in_ready;
   assign in_pop        = proc_rd && !in_empty && !rst;

   assign out_pop  = host_out_ready && !out_empty && !rst;
   assign out_push = proc_wr && !rst && (!out_full || out_pop);
   assign out_drop = proc_wr && !rst && out_full && !out_pop;

   assign proc_rd_stall  = in_empty || rst;
   assign proc_read_in   = (in_empty || rst) ? '0 : in_mem[in_rp];
   assign host_out_valid = !out_empty && !rst;
   assign host_out_data  = (out_empty || rst) ? '0 : out_mem[out_rp];

   always_ff @(posedge clock) begin
      if (in_push)
         in_mem[in_wp] <= host_in_data;
      if (out_push)
         out_mem[out_wp] <= proc_write_out;
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         in_wp    <= '0;
         in_rp    <= '0;
         in_cnt   <= '0;
         out_wp   <= '0;
         out_rp   <= '0;
         out_cnt  <= '0;
         overflow <= 1'b0;
      end else begin
         if (in_push)
            in_wp <= in_wp + 1'b1;
         if (in_pop)
            in_rp <= in_rp + 1'b1;
         case ({in_push, in_pop})
            2'b10:   in_cnt <= in_cnt + 1'b1;
            2'b01:   in_cnt <= in_cnt - 1'b1;
            default: in_cnt <= in_cnt;
         endcase

         if (out_push)
            out_wp <= out_wp + 1'b1;
         if (out_pop)
            out_rp <= out_rp + 1'b1;
         case ({out_push, out_pop})
            2'b10:   out_cnt <= out_cnt + 1'b1;
            2'b01:   out_cnt <= out_cnt - 1'b1;
            default: out_cnt <= out_cnt;
         endcase

         if (out_drop)
            overflow <= 1'b1;
      end
   end

`ifdef IO_BRIDGE_STATS_EN
   // Dropped writes never reach out_push, so they are not counted.
   always_ff @(posedge clock) begin
      if (rst) begin
         rd_count <= '0;
         wr_count <= '0;
      end else begin
         if (in_pop)
            rd_count <= rd_count + 16'd1;
         if (out_push)
            wr_count <= wr_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_io_bridge.sv
// tb/tb_io_bridge.sv - directed self-checking bench for io_bridge
module tb_io_bridge;

   logic        clock = 1'b0;
   logic        rst;
   logic [15:0] host_in_data;
   logic        host_in_valid;
   logic        host_in_ready;
   logic [15:0] proc_read_in;
   logic        proc_rd;
   logic        proc_rd_stall;
   logic [15:0] proc_write_out;
   logic        proc_wr;
   logic [15:0] host_out_data;
   logic        host_out_valid;
   logic        host_out_ready;
   logic        overflow;
`ifdef IO_BRIDGE_STATS_EN
   logic [15:0] rd_count;
   logic [15:0] wr_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   io_bridge dut (
      .clock          (clock),
      .rst            (rst),
      .host_in_data   (host_in_data),
      .host_in_valid  (host_in_valid),
      .host_in_ready  (host_in_ready),
      .proc_read_in   (proc_read_in),
      .proc_rd        (proc_rd),
      .proc_rd_stall  (proc_rd_stall),
      .proc_write_out (proc_write_out),
      .proc_wr        (proc_wr),
      .host_out_data  (host_out_data),
      .host_out_valid (host_out_valid),
      .host_out_ready (host_out_ready),
`ifdef IO_BRIDGE_STATS_EN
      .overflow       (overflow),
      .rd_count       (rd_count),
      .wr_count       (wr_count)
`else
      .overflow       (overflow)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic host_push(input logic [15:0] d);
      host_in_data  = d;
      host_in_valid = 1'b1;
      step();
      host_in_valid = 1'b0;
   endtask

   task automatic core_write(input logic [15:0] d);
      proc_write_out = d;
      proc_wr        = 1'b1;
      step();
      proc_wr        = 1'b0;
   endtask

   task automatic core_read();
      proc_rd = 1'b1;
      step();
      proc_rd = 1'b0;
   endtask

   logic [15:0] exp4 [4] = '{16'h000B, 16'h0003, 16'h0007, 16'h0008};
   logic [15:0] exp5 [4] = '{16'h0022, 16'h0033, 16'h0044, 16'h00AA};

   initial begin
      rst            = 1'b1;
      host_in_data   = '0;
      host_in_valid  = 1'b0;
      proc_rd        = 1'b0;
      proc_write_out = '0;
      proc_wr        = 1'b0;
      host_out_ready = 1'b0;

      // reset state
      step();
      step();
      check("rst_in_ready", host_in_ready, 0);
      check("rst_stall", proc_rd_stall, 1);
      check("rst_out_valid", host_out_valid, 0);
      check("rst_overflow", overflow, 0);
      check("rst_read_in", proc_read_in, 0);
      check("rst_out_data", host_out_data, 0);
      rst = 1'b0;
      #1;
      check("post_rst_ready", host_in_ready, 1);

      // single word fall-through and pop
      host_push(16'h13B0);
      check("ft_data", proc_read_in, 16'h13B0);
      check("ft_stall", proc_rd_stall, 0);
      core_read();
      check("pop_data", proc_read_in, 0);
      check("pop_stall", proc_rd_stall, 1);

      // simultaneous push and pop with one entry queued
      host_push(16'h0A0A);
      host_in_data  = 16'h0B0B;
      host_in_valid = 1'b1;
      proc_rd       = 1'b1;
      step();
      host_in_valid = 1'b0;
      proc_rd       = 1'b0;
      check("pp_data", proc_read_in, 16'h0B0B);
      check("pp_stall", proc_rd_stall, 0);
      core_read();
      check("pp_empty", proc_rd_stall, 1);

      // fill input FIFO, refuse extra word, refuse push-into-full even with pop
      for (int i = 1; i <= 4; i++)
         host_push(16'(i));
      check("full_ready", host_in_ready, 0);
      host_push(16'h0005);
      check("refuse_head", proc_read_in, 16'h0001);
      host_in_data  = 16'h0005;
      host_in_valid = 1'b1;
      proc_rd       = 1'b1;
      step();
      host_in_valid = 1'b0;
      proc_rd       = 1'b0;
      check("nobypass_head", proc_read_in, 16'h0002);
      check("nobypass_ready", host_in_ready, 1);
      for (int i = 2; i <= 4; i++) begin
         check($sformatf("order_%0d", i), proc_read_in, 32'(i));
         core_read();
      end
      check("drained_stall", proc_rd_stall, 1);
      core_read();
      check("empty_rd_stall", proc_rd_stall, 1);
      check("empty_rd_data", proc_read_in, 0);
      check("empty_rd_ready", host_in_ready, 1);

      // output FIFO overflow
      core_write(16'h000B);
      core_write(16'h0003);
      core_write(16'h0007);
      core_write(16'h0008);
      check("ofull_valid", host_out_valid, 1);
      check("ofull_noovf", overflow, 0);
      core_write(16'h0009);
      check("ovf_set", overflow, 1);
      host_out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("drain4_%0d", i), host_out_data, 32'(exp4[i]));
         step();
      end
      host_out_ready = 1'b0;
      check("drain4_valid", host_out_valid, 0);
      check("drain4_data", host_out_data, 0);
      check("ovf_sticky", overflow, 1);

      // push at full with same-cycle pop is not a drop
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("ovf_cleared", overflow, 0);
      core_write(16'h0011);
      core_write(16'h0022);
      core_write(16'h0033);
      core_write(16'h0044);
      host_out_ready = 1'b1;
      core_write(16'h00AA);
      host_out_ready = 1'b0;
      check("full_pp_ovf", overflow, 0);
      check("full_pp_head", host_out_data, 16'h0022);
      host_out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("drain5_%0d", i), host_out_data, 32'(exp5[i]));
         step();
      end
      host_out_ready = 1'b0;
      check("drain5_valid", host_out_valid, 0);

      // reset mid-traffic discards both FIFOs; handshakes ignored while rst high
      host_push(16'h0101);
      host_push(16'h0202);
      core_write(16'h0303);
      core_write(16'h0404);
      rst           = 1'b1;
      host_in_valid = 1'b1;
      host_in_data  = 16'h0505;
      proc_wr       = 1'b1;
      #1;
      check("rsthi_ready", host_in_ready, 0);
      check("rsthi_read_in", proc_read_in, 0);
      check("rsthi_out_data", host_out_data, 0);
      step();
      rst           = 1'b0;
      host_in_valid = 1'b0;
      proc_wr       = 1'b0;
      #1;
      check("r6_stall", proc_rd_stall, 1);
      check("r6_valid", host_out_valid, 0);
      check("r6_ovf", overflow, 0);
`ifdef IO_BRIDGE_STATS_EN
      check("r6_rd_count", rd_count, 0);
      check("r6_wr_count", wr_count, 0);
      for (int i = 0; i < 3; i++)
         host_push(16'(i + 16'h0100));
      for (int i = 0; i < 3; i++)
         core_read();
      core_read();
      core_write(16'h0C0C);
      core_write(16'h0D0D);
      check("rd_count3", rd_count, 3);
      check("wr_count2", wr_count, 2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
